// File: rtl/slot_bus_pkg.sv
// ---------------------------------------------------------------------------
// slot_bus_pkg
//   Shared definitions for the converter slot bus port: per-slot state
//   encoding, default parameter values and the width rules for the
//   turnaround counter and the slot-select field.
// ---------------------------------------------------------------------------
package slot_bus_pkg;

  typedef enum logic [1:0] {
    SLOT_IN       = 2'd0,
    SLOT_TURN_OUT = 2'd1,
    SLOT_OUT      = 2'd2,
    SLOT_TURN_IN  = 2'd3
  } slot_state_e;

  localparam int DEF_NUM_SLOTS         = 4;
  localparam int DEF_SLOT_WIDTH        = 6;
  localparam int DEF_TURNAROUND_CYCLES = 4;
  localparam int DEF_SYNC_STAGES       = 2;
  localparam bit DEF_RX_ON_CHANGE      = 1'b1;

  // Counter must hold the value TURNAROUND_CYCLES itself (it counts down to 0).
  function automatic int turn_cnt_width(input int turnaround_cycles);
    return (turnaround_cycles < 1) ? 1 : $clog2(turnaround_cycles + 1);
  endfunction

  // Slot-select field is at least one bit wide, even for a single slot.
  function automatic int slot_idx_width(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

endpackage

// File: rtl/slot_port_lane.sv
// ---------------------------------------------------------------------------
// slot_port_lane
//   One slot of the bus: direction FSM with break-before-make turnaround,
//   registered transmit word and output enable, input synchroniser and
//   change-detected receive strobe.
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   cmd_fire, cmd_dir_out   accepted direction command for this slot
//   cmd_ready               slot is settled (IN or OUT) and can take a command
//   tx_data/tx_valid        transmit word and strobe; tx_ready = settled OUT
//   rx_data/rx_valid        received word and one-cycle strobe
//   dir_out                 settled direction (1 = OUT), 0 while turning
//   pin_in                  raw pin values (asynchronous)
//   pin_out/pin_oe          registered drive value and output enable
// ---------------------------------------------------------------------------
module slot_port_lane
  import slot_bus_pkg::*;
#(
  parameter int SLOT_WIDTH        = DEF_SLOT_WIDTH,
  parameter int TURNAROUND_CYCLES = DEF_TURNAROUND_CYCLES,
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter bit RX_ON_CHANGE      = DEF_RX_ON_CHANGE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_fire,
  input  logic                  cmd_dir_out,
  output logic                  cmd_ready,
  input  logic [SLOT_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SLOT_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  dir_out,
  input  logic [SLOT_WIDTH-1:0] pin_in,
  output logic [SLOT_WIDTH-1:0] pin_out,
  output logic                  pin_oe
);

  localparam int                CNT_W     = turn_cnt_width(TURNAROUND_CYCLES);
  localparam logic [CNT_W-1:0]  TURN_LOAD = CNT_W'(TURNAROUND_CYCLES);

  slot_state_e                             state_q, state_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic                                    oe_q, oe_d;
  logic [SLOT_WIDTH-1:0]                   data_out_q, data_out_d;
  logic [SYNC_STAGES-1:0][SLOT_WIDTH-1:0]  sync_q, sync_d;
  logic [SLOT_WIDTH-1:0]                   last_q, last_d;
  logic                                    last_valid_q, last_valid_d;
  logic [SLOT_WIDTH-1:0]                   rx_data_q, rx_data_d;
  logic                                    rx_valid_q, rx_valid_d;
  logic [SLOT_WIDTH-1:0]                   sync_val;

  assign sync_val = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    last_d       = last_q;
    last_valid_d = last_valid_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    // Synchroniser shifts every cycle regardless of direction.
    sync_d       = {sync_q[SYNC_STAGES-2:0], pin_in};

    unique case (state_q)
      SLOT_IN: begin
        if (cmd_fire && cmd_dir_out) begin
          state_d = SLOT_TURN_OUT;
          cnt_d   = TURN_LOAD;
        end
      end
      SLOT_OUT: begin
        if (cmd_fire && !cmd_dir_out) begin
          state_d      = SLOT_TURN_IN;
          cnt_d        = TURN_LOAD;
          // Forget the last reported word so the first settled sample is reported.
          last_valid_d = 1'b0;
        end
      end
      SLOT_TURN_OUT: begin
        if (cnt_q == '0) state_d = SLOT_OUT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      SLOT_TURN_IN: begin
        if (cnt_q == '0) state_d = SLOT_IN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = SLOT_IN;
    endcase

    if ((state_q == SLOT_OUT) && tx_valid) begin
      data_out_d = tx_data;
    end

    if ((state_q == SLOT_IN) &&
        (!RX_ON_CHANGE || !last_valid_q || (sync_val != last_q))) begin
      rx_valid_d   = 1'b1;
      rx_data_d    = sync_val;
      last_d       = sync_val;
      last_valid_d = 1'b1;
    end

    // Enable follows the next state: it drops on the accepting edge of an
    // OUT->IN command and rises on the edge that enters OUT.
    oe_d = (state_d == SLOT_OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SLOT_IN;
      cnt_q        <= '0;
      oe_q         <= 1'b0;
      data_out_q   <= '0;
      sync_q       <= '0;
      last_q       <= '0;
      last_valid_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      oe_q         <= oe_d;
      data_out_q   <= data_out_d;
      sync_q       <= sync_d;
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
    end
  end

  assign cmd_ready = (state_q == SLOT_IN) || (state_q == SLOT_OUT);
  assign tx_ready  = (state_q == SLOT_OUT);
  assign dir_out   = (state_q == SLOT_OUT);
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign pin_out   = data_out_q;
  assign pin_oe    = oe_q;

endmodule

// File: rtl/slot_bus_port.sv
// ---------------------------------------------------------------------------
// slot_bus_port
//   Controller for the isolated converter slot bus: NUM_SLOTS independent
//   lanes of SLOT_WIDTH lines, exposed as split out/oe/in vectors.
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           direction command handshake
//   cmd_slot, cmd_dir_out         target slot and direction (1 = OUT)
//   tx_data/tx_valid/tx_ready     per-slot transmit word, strobe, ready
//   rx_data/rx_valid              per-slot received word and strobe
//   slot_dir_out                  per-slot settled direction
//   slot_data_in                  pin values (asynchronous)
//   slot_data_out/slot_data_oe    registered pin drive and enable
//   Slot i occupies bits [i*SLOT_WIDTH +: SLOT_WIDTH] of every data vector.
// ---------------------------------------------------------------------------
module slot_bus_port
  import slot_bus_pkg::*;
#(
  parameter int NUM_SLOTS         = DEF_NUM_SLOTS,
  parameter int SLOT_WIDTH        = DEF_SLOT_WIDTH,
  parameter int TURNAROUND_CYCLES = DEF_TURNAROUND_CYCLES,
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter bit RX_ON_CHANGE      = DEF_RX_ON_CHANGE,
  localparam int IDX_W            = slot_idx_width(NUM_SLOTS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [IDX_W-1:0]                cmd_slot,
  input  logic                            cmd_dir_out,
  input  logic [NUM_SLOTS*SLOT_WIDTH-1:0] tx_data,
  input  logic [NUM_SLOTS-1:0]            tx_valid,
  output logic [NUM_SLOTS-1:0]            tx_ready,
  output logic [NUM_SLOTS*SLOT_WIDTH-1:0] rx_data,
  output logic [NUM_SLOTS-1:0]            rx_valid,
  output logic [NUM_SLOTS-1:0]            slot_dir_out,
  input  logic [NUM_SLOTS*SLOT_WIDTH-1:0] slot_data_in,
  output logic [NUM_SLOTS*SLOT_WIDTH-1:0] slot_data_out,
  output logic [NUM_SLOTS-1:0]            slot_data_oe
);

  logic [NUM_SLOTS-1:0] lane_cmd_ready;
  logic [NUM_SLOTS-1:0] lane_cmd_fire;

  // An index with no lane behind it is always ready; the command is
  // accepted and dropped because no lane decodes it.
  always_comb begin
    cmd_ready = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (cmd_slot == IDX_W'(i)) cmd_ready = lane_cmd_ready[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_lane
      assign lane_cmd_fire[gi] = cmd_valid && cmd_ready && (cmd_slot == IDX_W'(gi));

      slot_port_lane #(
        .SLOT_WIDTH        (SLOT_WIDTH),
        .TURNAROUND_CYCLES (TURNAROUND_CYCLES),
        .SYNC_STAGES       (SYNC_STAGES),
        .RX_ON_CHANGE      (RX_ON_CHANGE)
      ) u_lane (
        .clk         (clk),
        .reset       (reset),
        .cmd_fire    (lane_cmd_fire[gi]),
        .cmd_dir_out (cmd_dir_out),
        .cmd_ready   (lane_cmd_ready[gi]),
        .tx_data     (tx_data[gi*SLOT_WIDTH +: SLOT_WIDTH]),
        .tx_valid    (tx_valid[gi]),
        .tx_ready    (tx_ready[gi]),
        .rx_data     (rx_data[gi*SLOT_WIDTH +: SLOT_WIDTH]),
        .rx_valid    (rx_valid[gi]),
        .dir_out     (slot_dir_out[gi]),
        .pin_in      (slot_data_in[gi*SLOT_WIDTH +: SLOT_WIDTH]),
        .pin_out     (slot_data_out[gi*SLOT_WIDTH +: SLOT_WIDTH]),
        .pin_oe      (slot_data_oe[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_slot_bus_port.sv
module tb_slot_bus_port;

  localparam int NS = 4;
  localparam int SW = 6;
  localparam int TC = 4;
  localparam int SS = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_slot;
  logic              cmd_dir_out;
  logic [NS*SW-1:0]  tx_data;
  logic [NS-1:0]     tx_valid;
  logic [NS-1:0]     tx_ready;
  logic [NS*SW-1:0]  rx_data;
  logic [NS-1:0]     rx_valid;
  logic [NS-1:0]     slot_dir_out;
  logic [NS*SW-1:0]  slot_data_in;
  logic [NS*SW-1:0]  slot_data_out;
  logic [NS-1:0]     slot_data_oe;

  slot_bus_port #(
    .NUM_SLOTS         (NS),
    .SLOT_WIDTH        (SW),
    .TURNAROUND_CYCLES (TC),
    .SYNC_STAGES       (SS),
    .RX_ON_CHANGE      (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_slot      (cmd_slot),
    .cmd_dir_out   (cmd_dir_out),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .slot_dir_out  (slot_dir_out),
    .slot_data_in  (slot_data_in),
    .slot_data_out (slot_data_out),
    .slot_data_oe  (slot_data_oe)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Receive scoreboard: expected strobes (slot, word, cycle) are queued when
  // the pins are driven and retired when the DUT strobes rx_valid.
  typedef struct {
    int          slot;
    logic [SW-1:0] data;
    int unsigned at;
  } rx_exp_t;

  rx_exp_t exp_q[$];
  int      rx_seen[NS];

  task automatic expect_rx(input int slot, input logic [SW-1:0] data, input int unsigned at);
    rx_exp_t e;
    e.slot = slot;
    e.data = data;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  int mon_idx;
  initial for (int i = 0; i < NS; i++) rx_seen[i] = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (rx_valid[i]) begin
        rx_seen[i]++;
        mon_idx = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
          if (mon_idx < 0 && exp_q[j].slot == i && exp_q[j].at == cyc) mon_idx = j;
        end
        if (mon_idx < 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected slot%0d: got strobe data %0h at cycle %0d, required no strobe",
                   i, rx_data[i*SW +: SW], cyc);
        end else begin
          chk($sformatf("rx_data slot%0d", i), 32'(rx_data[i*SW +: SW]), 32'(exp_q[mon_idx].data));
          exp_q.delete(mon_idx);
        end
      end
    end
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      if (exp_q[j].at < cyc) begin
        tests++;
        fails++;
        $display("FAIL rx_missing slot%0d: got no strobe, required data %0h at cycle %0d",
                 exp_q[j].slot, exp_q[j].data, exp_q[j].at);
        exp_q.delete(j);
      end
    end
  end

  typedef struct {
    logic [NS-1:0]    tx_valid;
    logic [SW-1:0]    word;
    logic [NS*SW-1:0] exp_out;
  } tx_vec_t;

  tx_vec_t tx_tab[5];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int unsigned t0;
  int unsigned oe_at;
  int          busy;
  int          base;

  initial begin
    // Slot 2 is OUT, every other slot IN while the table runs.
    tx_tab[0] = '{tx_valid: 4'b0100, word: 6'h2A, exp_out: 24'h02A000};
    tx_tab[1] = '{tx_valid: 4'b0000, word: 6'h15, exp_out: 24'h02A000};
    tx_tab[2] = '{tx_valid: 4'b0001, word: 6'h3F, exp_out: 24'h02A000};
    tx_tab[3] = '{tx_valid: 4'b0101, word: 6'h11, exp_out: 24'h011000};
    tx_tab[4] = '{tx_valid: 4'b1011, word: 6'h07, exp_out: 24'h011000};

    cmd_valid    = 1'b0;
    cmd_slot     = 2'd0;
    cmd_dir_out  = 1'b0;
    tx_data      = '0;
    tx_valid     = '0;
    slot_data_in = '0;

    // Reset state
    repeat (3) next_cycle();
    chk("rst_oe",        32'(slot_data_oe),  32'h0);
    chk("rst_out",       32'(slot_data_out), 32'h0);
    chk("rst_rx_valid",  32'(rx_valid),      32'h0);
    chk("rst_rx_data",   32'(rx_data),       32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready),     32'h1);
    chk("rst_dir",       32'(slot_dir_out),  32'h0);
    chk("rst_tx_ready",  32'(tx_ready),      32'h0);
    reset = 1'b0;
    for (int i = 0; i < NS; i++) expect_rx(i, '0, cyc + 1);
    repeat (3) next_cycle();

    // Slot 2 to OUT: oe rises on edge accept+TC+1
    cmd_slot = 2'd2; cmd_dir_out = 1'b1; cmd_valid = 1'b1;
    #1;
    chk("dir_ready_idle", 32'(cmd_ready), 32'h1);
    t0 = cyc;
    next_cycle();
    cmd_valid = 1'b0;
    busy  = 0;
    oe_at = 0;
    for (int c = 0; c < TC + 4; c++) begin
      if (!cmd_ready) busy++;
      if (slot_data_oe[2] && oe_at == 0) oe_at = cyc;
      next_cycle();
    end
    chk("dir_busy_cycles", 32'(busy),         32'(TC + 1));
    chk("dir_oe_rise",     32'(oe_at),        32'(t0 + TC + 2));
    chk("dir_tx_ready",    32'(tx_ready),     32'b0100);
    chk("dir_slot_dir",    32'(slot_dir_out), 32'b0100);

    // Transmit table
    for (int r = 0; r < 5; r++) begin
      tx_valid = tx_tab[r].tx_valid;
      tx_data  = {NS{tx_tab[r].word}};
      next_cycle();
      chk($sformatf("tx_row%0d_out", r), 32'(slot_data_out), 32'(tx_tab[r].exp_out));
      chk($sformatf("tx_row%0d_oe", r),  32'(slot_data_oe),  32'b0100);
    end
    tx_valid = '0;

    // Receive change detection on slot 1
    base = rx_seen[1];
    slot_data_in[1*SW +: SW] = 6'h15;
    expect_rx(1, 6'h15, cyc + SS + 1);
    repeat (10) next_cycle();
    slot_data_in[1*SW +: SW] = 6'h0F;
    expect_rx(1, 6'h0F, cyc + SS + 1);
    repeat (6) next_cycle();
    chk("rx_pulse_count", 32'(rx_seen[1] - base), 32'd2);

    // Slot 3 OUT, then back to IN while tx_valid is held
    cmd_slot = 2'd3; cmd_dir_out = 1'b1; cmd_valid = 1'b1;
    next_cycle();
    cmd_valid = 1'b0;
    repeat (TC + 2) next_cycle();
    chk("turn_tx_ready3", 32'(tx_ready[3]), 32'h1);
    slot_data_in[3*SW +: SW] = 6'h33;
    tx_data  = {6'h2C, 6'h00, 6'h00, 6'h00};
    tx_valid = 4'b1000;
    next_cycle();
    chk("turn_out3_load", 32'(slot_data_out[3*SW +: SW]), 32'h2C);
    cmd_slot = 2'd3; cmd_dir_out = 1'b0; cmd_valid = 1'b1;
    t0 = cyc;
    next_cycle();
    cmd_valid = 1'b0;
    chk("turn_oe3_drop",  32'(slot_data_oe),               32'b0100);
    chk("turn_out3_hold", 32'(slot_data_out[3*SW +: SW]), 32'h2C);
    expect_rx(3, 6'h33, t0 + TC + 3);
    repeat (TC + 4) next_cycle();
    tx_data = {6'h01, 6'h00, 6'h00, 6'h00};
    next_cycle();
    chk("turn_in_tx_ignored", 32'(slot_data_out[3*SW +: SW]), 32'h2C);
    chk("turn_dir3",          32'(slot_dir_out),              32'b0100);
    tx_valid = '0;

    // Reset during slot 0 TURN_OUT
    slot_data_in = '0;
    expect_rx(1, 6'h00, cyc + SS + 1);
    expect_rx(3, 6'h00, cyc + SS + 1);
    repeat (5) next_cycle();
    cmd_slot = 2'd0; cmd_dir_out = 1'b1; cmd_valid = 1'b1;
    next_cycle();
    cmd_valid = 1'b0;
    next_cycle();
    chk("mid_turn_ready0", 32'(cmd_ready), 32'h0);
    reset = 1'b1;
    #1;
    chk("mid_rst_oe_now",  32'(slot_data_oe),  32'h0);
    chk("mid_rst_out_now", 32'(slot_data_out), 32'h0);
    chk("mid_rst_dir_now", 32'(slot_dir_out),  32'h0);
    repeat (2) next_cycle();
    chk("mid_rst_oe_held", 32'(slot_data_oe),  32'h0);
    chk("mid_rst_ready",   32'(cmd_ready),     32'h1);
    reset = 1'b0;
    for (int i = 0; i < NS; i++) expect_rx(i, '0, cyc + 1);
    repeat (2) next_cycle();
    cmd_slot = 2'd0; cmd_dir_out = 1'b1; cmd_valid = 1'b1;
    #1;
    chk("recover_ready", 32'(cmd_ready), 32'h1);
    t0 = cyc;
    next_cycle();
    cmd_valid = 1'b0;
    oe_at = 0;
    for (int c = 0; c < TC + 4; c++) begin
      if (slot_data_oe[0] && oe_at == 0) oe_at = cyc;
      next_cycle();
    end
    chk("recover_oe_rise", 32'(oe_at),        32'(t0 + TC + 2));
    chk("recover_oe",      32'(slot_data_oe), 32'b0001);

    repeat (SS + 3) next_cycle();
    chk("rx_scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
